// File: rtl/pop_counter_pkg.sv
// Shared definitions for the pop counter bank: response FSM states,
// counter mode constants and the read-index range check.
package pop_counter_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // True when idx names an implemented channel.
  function automatic logic idx_valid(input logic [2:0] idx, input int num_ch);
    return (int'(idx) < num_ch);
  endfunction

endpackage

// File: rtl/pop_counter_chan.sv
// One pop counter channel: CNT_W-bit count plus sticky overflow flag.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : a pop happened this cycle
//   clr        : clear the channel (a same-cycle inc still counts as 1)
//   cnt, ovf   : current count and sticky overflow flag
module pop_counter_chan
  import pop_counter_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      // The clearing read already sampled the old value, so a pop arriving
      // in the same cycle becomes the first count after the clear.
      cnt <= {{(CNT_W-1){1'b0}}, inc};
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf <= 1'b1;
        cnt <= (SATURATE == MODE_SAT) ? CNT_MAX : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pop_counter_bank.sv
// Bank of NUM_CH pop counters with a registered, idle-gated read port.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   pop        : per-channel pop strobes
//   idle       : link idle; reads are accepted only while high
//   rd_req     : read request; rd_idx selects the channel, rd_clear clears it
//   rd_ready   : combinational copy of idle
//   valid      : one-cycle response strobe, one cycle after an accepted read
//   data_out   : sampled count, ovf_out : sampled sticky overflow flag
//   err        : response was for an out-of-range index
// data_out/ovf_out/err hold the last response while valid is low.
module pop_counter_bank
  import pop_counter_pkg::*;
#(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 5,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              idle,
  input  logic              rd_req,
  input  logic [2:0]        rd_idx,
  input  logic              rd_clear,
  output logic              rd_ready,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              ovf_out,
  output logic              err
);

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] clr;
  logic              accept;
  logic              idx_ok;
  logic [CNT_W-1:0]  mux_cnt;
  logic              mux_ovf;
  state_t            state;
  state_t            state_nxt;

  assign rd_ready = idle;
  assign accept   = rd_req & rd_ready;
  assign idx_ok   = idx_valid(rd_idx, NUM_CH);

  // Read mux and clear decode. An out-of-range index matches no channel,
  // so it reads as zero and clears nothing.
  always_comb begin
    mux_cnt = '0;
    mux_ovf = 1'b0;
    clr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_idx == 3'(i)) begin
        mux_cnt = cnt[i];
        mux_ovf = ovf[i];
        clr[i]  = accept & rd_clear;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pop_counter_chan #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .inc  (pop[g]),
      .clr  (clr[g]),
      .cnt  (cnt[g]),
      .ovf  (ovf[g])
    );
  end

  // Response stage: request accepted at edge N is presented after edge N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  state_nxt = accept ? S_RESP : S_WAIT;
      S_RESP:  state_nxt = accept ? S_RESP : S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  assign valid = (state == S_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      ovf_out  <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      data_out <= mux_cnt;
      ovf_out  <= mux_ovf;
      err      <= ~idx_ok;
    end
  end

endmodule

// File: tb/tb_pop_counter_bank.sv
module tb_pop_counter_bank;

  localparam int NCH  = 5;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] pop = '0;
  logic           idle = 1'b0;
  logic           rd_req = 1'b0;
  logic [2:0]     rd_idx = '0;
  logic           rd_clear = 1'b0;

  logic           rd_ready_w, valid_w, ovf_w, err_w;
  logic [CW-1:0]  data_w;
  logic           rd_ready_s, valid_s, ovf_s, err_s;
  logic [CW-1:0]  data_s;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pop_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_clear(rd_clear), .rd_ready(rd_ready_w),
    .valid(valid_w), .data_out(data_w), .ovf_out(ovf_w), .err(err_w)
  );

  pop_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_clear(rd_clear), .rd_ready(rd_ready_s),
    .valid(valid_s), .data_out(data_s), .ovf_out(ovf_s), .err(err_s)
  );

  // Behavioural model: integer counters per channel for each mode.
  int m_cw [NCH];
  int m_cs [NCH];
  bit m_ow [NCH];
  bit m_os [NCH];
  bit e_valid, e_err, e_ow, e_os;
  int e_dw, e_ds;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_cw[i] = 0; m_cs[i] = 0; m_ow[i] = 0; m_os[i] = 0;
      end
      e_valid = 0; e_err = 0; e_ow = 0; e_os = 0; e_dw = 0; e_ds = 0;
    end else begin
      int  idx;
      bit  acc;
      idx = int'(rd_idx);
      acc = rd_req && idle;
      e_valid = acc;
      if (acc) begin
        if (idx < NCH) begin
          e_dw = m_cw[idx]; e_ow = m_ow[idx];
          e_ds = m_cs[idx]; e_os = m_os[idx];
          e_err = 0;
        end else begin
          e_dw = 0; e_ow = 0; e_ds = 0; e_os = 0; e_err = 1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (acc && rd_clear && idx == i) begin
          m_cw[i] = pop[i] ? 1 : 0; m_cs[i] = pop[i] ? 1 : 0;
          m_ow[i] = 0; m_os[i] = 0;
        end else if (pop[i]) begin
          if (m_cw[i] == CMAX) m_ow[i] = 1;
          m_cw[i] = (m_cw[i] + 1) % (CMAX + 1);
          if (m_cs[i] == CMAX) m_os[i] = 1;
          else m_cs[i] = m_cs[i] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the edge.
  always @(posedge clk) begin
    #2;
    if (chk_en && !reset) begin
      check("rd_ready_w", 32'(rd_ready_w), 32'(idle));
      check("rd_ready_s", 32'(rd_ready_s), 32'(idle));
      check("valid_w", 32'(valid_w), 32'(e_valid));
      check("valid_s", 32'(valid_s), 32'(e_valid));
      check("err_w", 32'(err_w), 32'(e_err));
      check("err_s", 32'(err_s), 32'(e_err));
      check("data_w", 32'(data_w), 32'(e_dw));
      check("ovf_w", 32'(ovf_w), 32'(e_ow));
      check("data_s", 32'(data_s), 32'(e_ds));
      check("ovf_s", 32'(ovf_s), 32'(e_os));
    end
  end

  // Drive one cycle's inputs, then return 4 time units after the edge.
  task automatic step(input logic [NCH-1:0] p, input logic rq, input logic [2:0] ix,
                      input logic cl, input logic id);
    pop = p; rd_req = rq; rd_idx = ix; rd_clear = cl; idle = id;
    @(posedge clk);
    #4;
  endtask

  initial begin
    // Reset asserted mid-cycle from power-up.
    #1 reset = 1'b1;
    #1;
    check("rst_valid", 32'(valid_w), 32'd0);
    check("rst_data", 32'(data_w), 32'd0);
    check("rst_ovf", 32'(ovf_w), 32'd0);
    check("rst_err", 32'(err_w), 32'd0);
    @(posedge clk); #4;
    @(posedge clk); #4;
    reset = 1'b0;
    chk_en = 1;

    // Every channel reads zero after reset.
    for (int i = 0; i < NCH; i++) begin
      step('0, 1'b1, 3'(i), 1'b0, 1'b1);
      check("post_rst_data", 32'(data_w), 32'd0);
      check("post_rst_valid", 32'(valid_w), 32'd1);
    end
    step('0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("idle_novalid", 32'(valid_w), 32'd0);

    // 7 pops on ch2, 3 on ch4, overlapping in the first three cycles.
    for (int k = 0; k < 7; k++)
      step((k < 3) ? 5'b10100 : 5'b00100, 1'b0, 3'd0, 1'b0, 1'b1);
    step('0, 1'b1, 3'd2, 1'b0, 1'b1);
    check("ch2_data", 32'(data_w), 32'd7);
    check("ch2_valid", 32'(valid_w), 32'd1);
    step('0, 1'b1, 3'd4, 1'b0, 1'b1);
    check("ch4_data", 32'(data_w), 32'd3);
    check("ch4_valid", 32'(valid_w), 32'd1);
    step('0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("b2b_end_valid", 32'(valid_w), 32'd0);
    check("hold_data", 32'(data_w), 32'd3);

    // Wrap overflow on ch0.
    for (int k = 0; k < 33; k++) step(5'b00001, 1'b0, 3'd0, 1'b0, 1'b1);
    step('0, 1'b1, 3'd0, 1'b0, 1'b1);
    check("wrap_data", 32'(data_w), 32'd1);
    check("wrap_ovf", 32'(ovf_w), 32'd1);
    check("sat0_data", 32'(data_s), 32'd31);

    // Saturation on ch1.
    for (int k = 0; k < 40; k++) step(5'b00010, 1'b0, 3'd0, 1'b0, 1'b1);
    step('0, 1'b1, 3'd1, 1'b0, 1'b1);
    check("sat_data", 32'(data_s), 32'd31);
    check("sat_ovf", 32'(ovf_s), 32'd1);
    check("wrap40_data", 32'(data_w), 32'd8);

    // Clear with simultaneous pop on ch3.
    for (int k = 0; k < 9; k++) step(5'b01000, 1'b0, 3'd0, 1'b0, 1'b1);
    step(5'b01000, 1'b1, 3'd3, 1'b1, 1'b1);
    check("clr_resp", 32'(data_w), 32'd9);
    step('0, 1'b1, 3'd3, 1'b0, 1'b1);
    check("after_clr_data", 32'(data_w), 32'd1);
    check("after_clr_ovf", 32'(ovf_w), 32'd0);

    // Clear ch0 (overflowed) then confirm both fields cleared.
    step('0, 1'b1, 3'd0, 1'b1, 1'b1);
    step('0, 1'b1, 3'd0, 1'b0, 1'b1);
    check("clr_ovf_data", 32'(data_w), 32'd0);
    check("clr_ovf_flag", 32'(ovf_w), 32'd0);

    // Gating: request with a clear while not idle is ignored.
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b1, 3'd2, 1'b1, 1'b0);
      check("gated_valid", 32'(valid_w), 32'd0);
    end
    step('0, 1'b1, 3'd2, 1'b0, 1'b1);
    check("ungated_valid", 32'(valid_w), 32'd1);
    check("ungated_data", 32'(data_w), 32'd7);
    step('0, 1'b0, 3'd2, 1'b0, 1'b1);
    check("single_resp", 32'(valid_w), 32'd0);

    // Out-of-range index with clear: error response, nothing changes.
    step('0, 1'b1, 3'd6, 1'b1, 1'b1);
    check("oor_valid", 32'(valid_w), 32'd1);
    check("oor_err", 32'(err_w), 32'd1);
    check("oor_data", 32'(data_w), 32'd0);
    step('0, 1'b1, 3'd4, 1'b0, 1'b1);
    check("oor_nochg", 32'(data_w), 32'd3);
    check("oor_err_clr", 32'(err_w), 32'd0);

    // Reset in the middle of a response.
    step('0, 1'b1, 3'd2, 1'b0, 1'b1);
    check("pre_rst_valid", 32'(valid_w), 32'd1);
    rd_req = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid_w), 32'd0);
    check("mid_rst_data", 32'(data_w), 32'd0);
    @(posedge clk); #4;
    reset = 1'b0;
    step('0, 1'b1, 3'd2, 1'b0, 1'b1);
    check("rst_ch2_data", 32'(data_w), 32'd0);
    step('0, 1'b0, 3'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
